// File: rtl/global_dep_tracker.sv
// Slot table of in-flight batch dependency unions. It answers registered
// RAW/WAW/WAR conflict queries against every live slot owned by someone else.
module global_dep_tracker #(
  parameter int  MAX_DEPENDENCIES     = 256,
  parameter int  MAX_INFLIGHT_BATCHES = 8,
  localparam int SLOT_W               = $clog2(MAX_INFLIGHT_BATCHES)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_reg_valid,
  output logic                            o_reg_ready,
  input  logic [MAX_DEPENDENCIES-1:0]     i_reg_read_deps,
  input  logic [MAX_DEPENDENCIES-1:0]     i_reg_write_deps,
  input  logic [63:0]                     i_reg_owner_id,
  output logic                            o_reg_ack,
  output logic [SLOT_W-1:0]               o_reg_slot,
  input  logic                            i_retire_valid,
  input  logic [SLOT_W-1:0]               i_retire_slot,
  input  logic                            i_query_valid,
  input  logic [MAX_DEPENDENCIES-1:0]     i_query_read_deps,
  input  logic [MAX_DEPENDENCIES-1:0]     i_query_write_deps,
  input  logic [63:0]                     i_query_owner_id,
  output logic                            o_resp_valid,
  output logic                            o_resp_conflict,
  output logic                            o_resp_raw,
  output logic                            o_resp_waw,
  output logic                            o_resp_war,
  output logic [MAX_INFLIGHT_BATCHES-1:0] o_resp_slot_mask,
  output logic [SLOT_W:0]                 o_inflight_count,
  output logic                            o_table_full,
  output logic [31:0]                     o_retire_errors,
  output logic [31:0]                     o_batches_registered
);
  localparam int N  = MAX_INFLIGHT_BATCHES;
  localparam int D  = MAX_DEPENDENCIES;
  localparam int CW = SLOT_W + 1;

  logic [N-1:0]        r_valid;
  logic [D-1:0]        r_rd  [N];
  logic [D-1:0]        r_wr  [N];
  logic [63:0]         r_own [N];

  logic                r_reg_ack;
  logic [SLOT_W-1:0]   r_reg_slot;
  logic                r_resp_valid;
  logic                r_raw;
  logic                r_waw;
  logic                r_war;
  logic [N-1:0]        r_mask;
  logic [CW-1:0]       r_count;
  logic                r_full;
  logic [31:0]         r_rerr;
  logic [31:0]         r_breg;

  logic [SLOT_W-1:0]   w_free_idx;
  logic                w_accept;
  logic                w_slot_live;
  logic                w_retire_ok;
  logic                w_retire_bad;
  logic [N-1:0]        w_valid_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic [N-1:0]        w_raw;
  logic [N-1:0]        w_waw;
  logic [N-1:0]        w_war;
  logic                w_hit;

  // Descending scan so the lowest free index wins.
  always_comb begin
    w_free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = SLOT_W'(i);
    end
  end

  assign w_accept     = i_reg_valid & ~r_full;
  assign w_slot_live  = r_valid[i_retire_slot];
  assign w_retire_ok  = i_retire_valid & w_slot_live;
  assign w_retire_bad = i_retire_valid & ~w_slot_live;
  assign w_count_nxt  = r_count + CW'(w_accept) - CW'(w_retire_ok);

  // Allocation uses pre-edge free slots, so a slot retired this cycle stays free.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_retire_ok) w_valid_nxt[i_retire_slot] = 1'b0;
    if (w_accept)    w_valid_nxt[w_free_idx]    = 1'b1;
  end

  always_comb begin
    w_raw = '0;
    w_waw = '0;
    w_war = '0;
    w_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_hit    = r_valid[i] && (r_own[i] != i_query_owner_id);
      w_raw[i] = w_hit && |(i_query_read_deps  & r_wr[i]);
      w_waw[i] = w_hit && |(i_query_write_deps & r_wr[i]);
      w_war[i] = w_hit && |(i_query_write_deps & r_rd[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid      <= '0;
      r_reg_ack    <= 1'b0;
      r_reg_slot   <= '0;
      r_resp_valid <= 1'b0;
      r_raw        <= 1'b0;
      r_waw        <= 1'b0;
      r_war        <= 1'b0;
      r_mask       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_rerr       <= '0;
      r_breg       <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == CW'(N));
      r_reg_ack    <= w_accept;
      r_reg_slot   <= w_accept ? w_free_idx : '0;
      if (w_accept) r_breg <= r_breg + 32'd1;
      if (w_retire_bad && (r_rerr != 32'hFFFF_FFFF)) r_rerr <= r_rerr + 32'd1;
      r_resp_valid <= i_query_valid;
      r_raw        <= i_query_valid & (|w_raw);
      r_waw        <= i_query_valid & (|w_waw);
      r_war        <= i_query_valid & (|w_war);
      r_mask       <= i_query_valid ? (w_raw | w_waw | w_war) : '0;
    end
  end

  // Payload storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rd[w_free_idx]  <= i_reg_read_deps;
      r_wr[w_free_idx]  <= i_reg_write_deps;
      r_own[w_free_idx] <= i_reg_owner_id;
    end
  end

  assign o_reg_ready          = ~r_full;
  assign o_reg_ack            = r_reg_ack;
  assign o_reg_slot           = r_reg_slot;
  assign o_resp_valid         = r_resp_valid;
  assign o_resp_raw           = r_raw;
  assign o_resp_waw           = r_waw;
  assign o_resp_war           = r_war;
  assign o_resp_conflict      = r_raw | r_waw | r_war;
  assign o_resp_slot_mask     = r_mask;
  assign o_inflight_count     = r_count;
  assign o_table_full         = r_full;
  assign o_retire_errors      = r_rerr;
  assign o_batches_registered = r_breg;

endmodule

// File: tb/tb_global_dep_tracker.sv
// Scenario bench for global_dep_tracker: a behavioural table model feeds ack/response
// queues that a negedge monitor drains, and each scenario task adds fixed-value checks.
module tb_global_dep_tracker;
  localparam int D = 256;
  localparam int N = 8;
  localparam int SW = 3;

  typedef struct packed {
    logic         raw;
    logic         waw;
    logic         war;
    logic [N-1:0] mask;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_valid = 1'b0;
  logic          reg_ready;
  logic [D-1:0]  reg_read_deps = '0;
  logic [D-1:0]  reg_write_deps = '0;
  logic [63:0]   reg_owner_id = '0;
  logic          reg_ack;
  logic [SW-1:0] reg_slot;
  logic          retire_valid = 1'b0;
  logic [SW-1:0] retire_slot = '0;
  logic          query_valid = 1'b0;
  logic [D-1:0]  query_read_deps = '0;
  logic [D-1:0]  query_write_deps = '0;
  logic [63:0]   query_owner_id = '0;
  logic          resp_valid, resp_conflict, resp_raw, resp_waw, resp_war;
  logic [N-1:0]  resp_slot_mask;
  logic [SW:0]   inflight_count;
  logic          table_full;
  logic [31:0]   retire_errors;
  logic [31:0]   batches_registered;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_valid [N];
  logic [D-1:0] m_rd   [N];
  logic [D-1:0] m_wr   [N];
  logic [63:0] m_own   [N];
  int          m_cnt = 0;
  int unsigned m_breg = 0;
  int unsigned m_rerr = 0;
  resp_t       q_resp[$];
  int          q_ack[$];

  global_dep_tracker #(.MAX_DEPENDENCIES(D), .MAX_INFLIGHT_BATCHES(N)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_valid(reg_valid), .o_reg_ready(reg_ready),
    .i_reg_read_deps(reg_read_deps), .i_reg_write_deps(reg_write_deps),
    .i_reg_owner_id(reg_owner_id), .o_reg_ack(reg_ack), .o_reg_slot(reg_slot),
    .i_retire_valid(retire_valid), .i_retire_slot(retire_slot),
    .i_query_valid(query_valid), .i_query_read_deps(query_read_deps),
    .i_query_write_deps(query_write_deps), .i_query_owner_id(query_owner_id),
    .o_resp_valid(resp_valid), .o_resp_conflict(resp_conflict),
    .o_resp_raw(resp_raw), .o_resp_waw(resp_waw), .o_resp_war(resp_war),
    .o_resp_slot_mask(resp_slot_mask), .o_inflight_count(inflight_count),
    .o_table_full(table_full), .o_retire_errors(retire_errors),
    .o_batches_registered(batches_registered)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] bitv(input int b);
    logic [D-1:0] v;
    v = '0;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic clr();
    reg_valid = 0; reg_read_deps = '0; reg_write_deps = '0; reg_owner_id = '0;
    retire_valid = 0; retire_slot = '0;
    query_valid = 0; query_read_deps = '0; query_write_deps = '0; query_owner_id = '0;
  endtask

  // Advance one clock: model the edge from the currently driven inputs, queue expectations.
  task automatic cycle();
    resp_t e;
    bit acc, rv, qv;
    int fi, rs;
    logic [D-1:0] rd, wr;
    logic [63:0] own;
    acc = reg_valid && (m_cnt != N);
    fi = -1;
    for (int i = 0; i < N; i++) if (!m_valid[i] && fi < 0) fi = i;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_own[i] != query_owner_id) begin
        e.mask[i] = |(query_read_deps & m_wr[i]) | |(query_write_deps & m_wr[i]) |
                    |(query_write_deps & m_rd[i]);
        e.raw = e.raw | (|(query_read_deps & m_wr[i]));
        e.waw = e.waw | (|(query_write_deps & m_wr[i]));
        e.war = e.war | (|(query_write_deps & m_rd[i]));
      end
    end
    qv = query_valid; rv = retire_valid; rs = int'(retire_slot);
    rd = reg_read_deps; wr = reg_write_deps; own = reg_owner_id;
    @(posedge clk);
    if (rv) begin
      if (m_valid[rs]) m_valid[rs] = 0;
      else if (m_rerr != 32'hFFFF_FFFF) m_rerr++;
    end
    if (acc) begin
      m_valid[fi] = 1; m_rd[fi] = rd; m_wr[fi] = wr; m_own[fi] = own;
      m_breg++;
      q_ack.push_back(fi);
    end
    if (qv) q_resp.push_back(e);
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_cnt += int'(m_valid[i]);
    #2;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      resp_t e;
      int s;
      if (resp_valid) begin
        n_checks++;
        if (q_resp.size() == 0) begin
          n_errors++; $display("FAIL resp_unexpected resp_valid=1 want 0");
        end else begin
          e = q_resp.pop_front();
          if ({resp_raw, resp_waw, resp_war, resp_conflict, resp_slot_mask} !==
              {e.raw, e.waw, e.war, e.raw | e.waw | e.war, e.mask}) begin
            n_errors++;
            $display("FAIL resp_flags got r%0b w%0b a%0b c%0b m%h want r%0b w%0b a%0b m%h",
                     resp_raw, resp_waw, resp_war, resp_conflict, resp_slot_mask,
                     e.raw, e.waw, e.war, e.mask);
          end
        end
      end else begin
        n_checks++;
        if (q_resp.size() != 0) begin
          void'(q_resp.pop_front());
          n_errors++; $display("FAIL resp_missing resp_valid=0 want 1");
        end else if ({resp_raw, resp_waw, resp_war, resp_conflict, resp_slot_mask} !== '0) begin
          n_errors++; $display("FAIL resp_idle_flags got nonzero flags want 0");
        end
      end
      n_checks++;
      if (reg_ack) begin
        if (q_ack.size() == 0) begin
          n_errors++; $display("FAIL ack_unexpected reg_ack=1 want 0");
        end else begin
          s = q_ack.pop_front();
          if (int'(reg_slot) != s) begin
            n_errors++; $display("FAIL ack_slot got %0d want %0d", reg_slot, s);
          end
        end
      end else if (q_ack.size() != 0) begin
        void'(q_ack.pop_front());
        n_errors++; $display("FAIL ack_missing reg_ack=0 want 1");
      end
      n_checks++;
      if (int'(inflight_count) != m_cnt || table_full !== (m_cnt == N) ||
          reg_ready !== (m_cnt != N)) begin
        n_errors++;
        $display("FAIL occupancy got cnt=%0d full=%0b ready=%0b want cnt=%0d",
                 inflight_count, table_full, reg_ready, m_cnt);
      end
      n_checks++;
      if (batches_registered !== m_breg || retire_errors !== m_rerr) begin
        n_errors++;
        $display("FAIL counters got reg=%0d err=%0d want reg=%0d err=%0d",
                 batches_registered, retire_errors, m_breg, m_rerr);
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    clr();
    q_resp.delete(); q_ack.delete();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_cnt = 0; m_breg = 0; m_rerr = 0;
    #1;
    n_checks++;
    if (inflight_count !== '0 || resp_valid !== 0 || reg_ack !== 0 || reg_ready !== 1 ||
        table_full !== 0 || batches_registered !== '0 || retire_errors !== '0) begin
      n_errors++;
      $display("FAIL reset_state got cnt=%0d resp=%0b ack=%0b ready=%0b full=%0b",
               inflight_count, resp_valid, reg_ack, reg_ready, table_full);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  task automatic reg_one(input int own, input int rdb, input int wrb, input int exp_slot);
    reg_valid = 1; reg_owner_id = 64'(own);
    reg_read_deps = bitv(rdb); reg_write_deps = bitv(wrb);
    cycle();
    reg_valid = 0;
    n_checks++;
    if (reg_ack !== 1 || int'(reg_slot) != exp_slot) begin
      n_errors++; $display("FAIL reg_slot got ack=%0b slot=%0d want slot %0d", reg_ack, reg_slot, exp_slot);
    end
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
  endtask

  task automatic test_register();
    do_reset();
    for (int i = 0; i < 3; i++) reg_one(i + 1, -1, i, i);
    n_checks++;
    if (inflight_count !== 4'd3 || batches_registered !== 32'd3) begin
      n_errors++; $display("FAIL reg3_counts got cnt=%0d reg=%0d want 3 3", inflight_count, batches_registered);
    end
  endtask

  task automatic test_full();
    for (int i = 3; i < N; i++) reg_one(i + 1, -1, 10 + i, i);
    n_checks++;
    if (table_full !== 1 || reg_ready !== 0) begin
      n_errors++; $display("FAIL full_flags got full=%0b ready=%0b want 1 0", table_full, reg_ready);
    end
    reg_valid = 1; reg_owner_id = 64'd99; reg_write_deps = bitv(200);
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if (reg_ack !== 0 || inflight_count !== 4'd8) begin
        n_errors++; $display("FAIL held_reject got ack=%0b cnt=%0d want 0 8", reg_ack, inflight_count);
      end
    end
    retire_valid = 1; retire_slot = 3'd4;
    cycle();
    retire_valid = 0;
    n_checks++;
    if (reg_ack !== 0 || reg_ready !== 1 || inflight_count !== 4'd7) begin
      n_errors++; $display("FAIL retire4 got ack=%0b ready=%0b cnt=%0d want 0 1 7", reg_ack, reg_ready, inflight_count);
    end
    cycle();
    n_checks++;
    if (reg_ack !== 1 || reg_slot !== 3'd4 || inflight_count !== 4'd8) begin
      n_errors++; $display("FAIL held_lands got ack=%0b slot=%0d cnt=%0d want 1 4 8", reg_ack, reg_slot, inflight_count);
    end
    clr();
  endtask

  task automatic test_query();
    int t_rd [6] = '{5, -1, -1, 5, -1, -1};
    int t_wr [6] = '{-1, 9, 5, -1, 9, 5};
    int t_own[6] = '{2, 2, 2, 1, 1, 1};
    logic [2:0] t_exp[6] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
    do_reset();
    reg_one(1, 9, 5, 0);
    for (int k = 0; k < 6; k++) begin
      query_valid = 1; query_read_deps = bitv(t_rd[k]);
      query_write_deps = bitv(t_wr[k]); query_owner_id = 64'(t_own[k]);
      cycle();
      n_checks++;
      if (resp_valid !== 1 || {resp_raw, resp_waw, resp_war} !== t_exp[k] ||
          resp_slot_mask !== ((t_exp[k] != 0) ? 8'h01 : 8'h00)) begin
        n_errors++;
        $display("FAIL query%0d got v=%0b rww=%b m=%h want rww=%b", k, resp_valid,
                 {resp_raw, resp_waw, resp_war}, resp_slot_mask, t_exp[k]);
      end
    end
    clr();
    cycle();
    n_checks++;
    if (resp_valid !== 0) begin
      n_errors++; $display("FAIL resp_pulse got resp_valid=%0b want 0", resp_valid);
    end
  endtask

  task automatic test_retire_register();
    do_reset();
    for (int i = 0; i < N; i++) reg_one(10 + i, -1, 20 + i, i);
    reg_valid = 1; reg_owner_id = 64'd50; retire_valid = 1; retire_slot = 3'd2;
    cycle();
    n_checks++;
    if (reg_ack !== 0 || inflight_count !== 4'd7) begin
      n_errors++; $display("FAIL full_same_cycle got ack=%0b cnt=%0d want 0 7", reg_ack, inflight_count);
    end
    retire_slot = 3'd3;
    cycle();
    n_checks++;
    if (reg_ack !== 1 || reg_slot !== 3'd2 || inflight_count !== 4'd7) begin
      n_errors++; $display("FAIL reg_retire_same got ack=%0b slot=%0d cnt=%0d want 1 2 7", reg_ack, reg_slot, inflight_count);
    end
    clr();
    cycle();
  endtask

  task automatic test_retire_errors();
    do_reset();
    for (int i = 0; i < 3; i++) reg_one(i + 1, -1, i, i);
    retire_valid = 1; retire_slot = 3'd6;
    cycle();
    cycle();
    clr();
    n_checks++;
    if (retire_errors !== 32'd2 || inflight_count !== 4'd3) begin
      n_errors++; $display("FAIL retire_err got err=%0d cnt=%0d want 2 3", retire_errors, inflight_count);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    reg_one(1, -1, 1, 0);
    reg_valid = 1; reg_owner_id = 64'd7; reg_read_deps = bitv(50);
    query_valid = 1; query_write_deps = bitv(50); query_owner_id = 64'd9;
    cycle();
    n_checks++;
    if (resp_valid !== 1 || resp_conflict !== 0) begin
      n_errors++; $display("FAIL same_cycle_query got v=%0b c=%0b want 1 0", resp_valid, resp_conflict);
    end
    reg_valid = 0; reg_read_deps = '0;
    cycle();
    n_checks++;
    if (resp_conflict !== 1 || resp_war !== 1 || resp_slot_mask !== 8'h02) begin
      n_errors++; $display("FAIL next_cycle_query got c=%0b war=%0b m=%h want 1 1 02", resp_conflict, resp_war, resp_slot_mask);
    end
    cycle();
    do_reset();
    cycle();
  endtask

  initial begin
    test_reset();
    test_register();
    test_full();
    test_query();
    test_retire_register();
    test_retire_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
